// File: rtl/dl_xor_arb_pkg.sv
// Shared helpers for the XOR arbiter slice.
package dl_xor_arb_pkg;

   // Index width for a requester count. A single requester still gets one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dl_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at ptr, ptr moves past the winner on advance.
module dl_rr_arb import dl_xor_arb_pkg::*; #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id
);

   logic [ID_W-1:0]               ptr;
   logic [NUM_REQ-1:0]            mask;
   logic [NUM_REQ-1:0]            hi;
   logic [NUM_REQ:0][ID_W-1:0]    id_acc;

   // Requests at or above ptr win first; otherwise wrap to the lowest index.
   genvar i;
   generate
      for (i = 0; i < NUM_REQ; i++) begin : g_lane
         assign mask[i]     = (ID_W'(i) >= ptr);
         assign id_acc[i+1] = id_acc[i] | (ID_W'(i) & {ID_W{gnt[i]}});
      end
   endgenerate

   assign id_acc[0] = '0;
   assign hi        = req & mask;
   assign gnt       = (|hi) ? (hi & (~hi + NUM_REQ'(1))) : (req & (~req + NUM_REQ'(1)));
   assign gnt_id    = id_acc[NUM_REQ];

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (advance)
         ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
   end

endmodule

// File: rtl/dl_xor.sv
// Shared bitwise XOR datapath.
module dl_xor #(
   parameter int NUM_BITS = 32
) (
   input  logic [NUM_BITS-1:0] in0,
   input  logic [NUM_BITS-1:0] in1,
   output logic [NUM_BITS-1:0] out
);

   assign out = in0 ^ in1;

endmodule

// File: rtl/dl_xor_arb.sv
// Shares one dl_xor among NUM_REQ requesters behind a one-entry registered response.
module dl_xor_arb import dl_xor_arb_pkg::*; #(
   parameter  int NUM_BITS = 32,
   parameter  int NUM_REQ  = 4,
   localparam int ID_W     = id_width(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_val,
   output logic [NUM_REQ-1:0]          req_rdy,
   input  logic [NUM_REQ*NUM_BITS-1:0] req_in0,
   input  logic [NUM_REQ*NUM_BITS-1:0] req_in1,
   output logic                        resp_val,
   input  logic                        resp_rdy,
   output logic [NUM_BITS-1:0]         resp_out,
   output logic [ID_W-1:0]             resp_id
);

   logic                           can_accept;
   logic                           xfer;
   logic [NUM_REQ-1:0]             gnt;
   logic [ID_W-1:0]                gnt_id;
   logic [NUM_REQ:0][NUM_BITS-1:0] op0_acc;
   logic [NUM_REQ:0][NUM_BITS-1:0] op1_acc;
   logic [NUM_BITS-1:0]            xor_out;

   assign can_accept = !resp_val || resp_rdy;
   assign req_rdy    = gnt & {NUM_REQ{can_accept && !rst}};
   assign xfer       = |(req_val & req_rdy);

   dl_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_val),
      .advance (xfer),
      .gnt     (gnt),
      .gnt_id  (gnt_id)
   );

   // AND-OR operand mux; gnt is one-hot or zero.
   genvar i;
   generate
      for (i = 0; i < NUM_REQ; i++) begin : g_mux
         assign op0_acc[i+1] = op0_acc[i] | (req_in0[i*NUM_BITS +: NUM_BITS] & {NUM_BITS{gnt[i]}});
         assign op1_acc[i+1] = op1_acc[i] | (req_in1[i*NUM_BITS +: NUM_BITS] & {NUM_BITS{gnt[i]}});
      end
   endgenerate

   assign op0_acc[0] = '0;
   assign op1_acc[0] = '0;

   dl_xor #(.NUM_BITS(NUM_BITS)) u_xor (
      .in0 (op0_acc[NUM_REQ]),
      .in1 (op1_acc[NUM_REQ]),
      .out (xor_out)
   );

   // Data and id only load on a transfer, so a drain leaves them holding.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_val <= 1'b0;
         resp_out <= '0;
         resp_id  <= '0;
      end else if (can_accept) begin
         resp_val <= xfer;
         if (xfer) begin
            resp_out <= xor_out;
            resp_id  <= gnt_id;
         end
      end
   end

endmodule

// File: tb/tb_dl_xor_arb.sv
// Directed plus random checks of dl_xor_arb against a queue-free behavioural model.
module tb_dl_xor_arb;

   localparam int NB = 32;
   localparam int NR = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req_val;
   logic [NR-1:0]    req_rdy;
   logic [NR*NB-1:0] req_in0;
   logic [NR*NB-1:0] req_in1;
   logic             resp_val;
   logic             resp_rdy;
   logic [NB-1:0]    resp_out;
   logic [1:0]       resp_id;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: pending response slot and rotation start.
   bit            m_val;
   logic [NB-1:0] m_out;
   int            m_id;
   int            m_ptr;

   always #5 clk = ~clk;

   dl_xor_arb #(.NUM_BITS(NB), .NUM_REQ(NR)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_in0  (req_in0),
      .req_in1  (req_in1),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_out (resp_out),
      .resp_id  (resp_id)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int winner();
      int j;
      for (int k = 0; k < NR; k++) begin
         j = (m_ptr + k) % NR;
         if (req_val[j]) return j;
      end
      return -1;
   endfunction

   task automatic randomize_data();
      for (int k = 0; k < NR; k++) begin
         req_in0[k*NB +: NB] = $urandom;
         req_in1[k*NB +: NB] = $urandom;
      end
   endtask

   // Check outputs mid-cycle, then advance the model across the edge.
   task automatic cycle();
      int            w;
      bit            ca;
      logic [NR-1:0] exp_rdy;
      @(negedge clk);
      ca      = !m_val || resp_rdy;
      w       = winner();
      exp_rdy = '0;
      if (!rst && ca && w >= 0) exp_rdy[w] = 1'b1;
      chk("req_rdy", req_rdy, exp_rdy);
      chk("resp_val", resp_val, m_val);
      chk("resp_out", resp_out, m_out);
      chk("resp_id", resp_id, m_id);
      @(posedge clk);
      if (rst) begin
         m_val = 0; m_out = '0; m_id = 0; m_ptr = 0;
      end else if (ca) begin
         if (w >= 0) begin
            m_val = 1;
            m_out = req_in0[w*NB +: NB] ^ req_in1[w*NB +: NB];
            m_id  = w;
            m_ptr = (w + 1) % NR;
         end else begin
            m_val = 0;
         end
      end
      #1;
   endtask

   initial begin
      m_val = 0; m_out = '0; m_id = 0; m_ptr = 0;
      rst = 1'b1; req_val = 4'b1111; resp_rdy = 1'b1;
      randomize_data();

      // Reset held two cycles with everyone requesting
      cycle(); cycle();
      rst = 1'b0;
      cycle();
      chk("first_gnt_id", resp_id, 0);
      chk("first_gnt_val", resp_val, 1);

      req_val = '0;
      cycle();

      // Single request on requester 2
      req_val = 4'b0100;
      req_in0[2*NB +: NB] = 32'hFFFF_0000;
      req_in1[2*NB +: NB] = 32'h0F0F_0F0F;
      #1;
      chk("single_rdy", req_rdy, 4'b0100);
      cycle();
      chk("single_out", resp_out, 32'hF0F0_0F0F);
      chk("single_id", resp_id, 2);

      // Round-robin from a fresh pointer
      rst = 1'b1; req_val = 4'b1111;
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         randomize_data();
         cycle();
         chk("rr_id", resp_id, k % 4);
         chk("rr_val", resp_val, 1);
      end

      // Backpressure with response id 1 pending
      resp_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("bp_id", resp_id, 1);
      end
      resp_rdy = 1'b1;
      cycle();
      chk("bp_release_id", resp_id, 2);
      chk("bp_release_val", resp_val, 1);

      // Priority skip from ptr=1 with only 0 and 3 valid
      req_val = 4'b0001;
      cycle();
      req_val = 4'b1001;
      cycle();
      chk("skip_first", resp_id, 3);
      cycle();
      chk("skip_second", resp_id, 0);
      req_val = 4'b0011;
      cycle();
      chk("skip_ptr", resp_id, 1);

      // Reset mid-stream with id 1 pending
      rst = 1'b1; req_val = 4'b0110;
      cycle();
      chk("mid_rst_val", resp_val, 0);
      rst = 1'b0;
      cycle();
      chk("mid_rst_gnt", resp_id, 1);

      // Random traffic, backpressure and occasional reset
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 49) == 0);
         req_val  = NR'($urandom);
         resp_rdy = ($urandom_range(0, 3) != 0);
         randomize_data();
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
